// File: rtl/ifetch_responder_if.sv
// Fetch-port bundle between the IF front end (master) and ifetch_responder (slave).
// Handshakes: a beat moves on a posedge where valid && ready; valid never waits on ready.
interface ifetch_responder_if #(
  parameter int MEM_AW = 8
) ();
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_pc;
  logic              flush;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_ir;
  logic [31:0]       rsp_pc;
  logic              rsp_err;
  logic              ld_we;
  logic [MEM_AW-1:0] ld_addr;
  logic [31:0]       ld_data;

  modport master (
    output req_valid, req_pc, flush, rsp_ready, ld_we, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_ir, rsp_pc, rsp_err
  );

  modport slave (
    input  req_valid, req_pc, flush, rsp_ready, ld_we, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_ir, rsp_pc, rsp_err
  );
endinterface

// File: rtl/ifetch_responder.sv
// Instruction-fetch responder: loadable ROM, LAT-stage read pipe, credit-limited response FIFO.
// Optional IFR_STATS_EN adds saturating stat_rsp / stat_squash counters.
module ifetch_responder #(
  parameter int MEM_AW     = 8,  // must match the interface MEM_AW
  parameter int LAT        = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  ifetch_responder_if.slave   bus
`ifdef IFR_STATS_EN
  ,
  output logic [15:0]         stat_rsp,
  output logic [15:0]         stat_squash
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [31:0]           rom [2**MEM_AW];

  logic                  accept;
  logic                  pop;
  logic                  push;
  logic                  fetch_err;
  logic [31:0]           fetch_ir;

  logic [CW-1:0]         occ;
  logic [CW-1:0]         fifo_cnt;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;

  logic [LAT-1:0]        p_valid;
  logic [LAT-1:0]        p_err;
  logic [31:0]           p_ir [LAT];
  logic [31:0]           p_pc [LAT];

  logic [FIFO_DEPTH-1:0] f_err;
  logic [31:0]           f_ir [FIFO_DEPTH];
  logic [31:0]           f_pc [FIFO_DEPTH];

  logic [31:0]           last_ir;
  logic [31:0]           last_pc;
  logic                  last_err;

  assign accept = bus.req_valid && bus.req_ready;
  assign pop    = bus.rsp_valid && bus.rsp_ready;
  assign push   = p_valid[LAT-1];

  // Misaligned or beyond the 2^MEM_AW-word ROM returns the bubble code.
  assign fetch_err = (bus.req_pc[1:0] != 2'b00) ||
                     ((bus.req_pc >> (MEM_AW + 2)) != 32'd0);
  assign fetch_ir  = fetch_err ? 32'hFFFF_FFFF : rom[bus.req_pc[MEM_AW+1:2]];

  // Credits count both pipe and FIFO entries, so the FIFO can never overflow.
  assign bus.req_ready = !rst && !bus.flush && (occ < CW'(FIFO_DEPTH));
  assign bus.rsp_valid = (fifo_cnt != '0);
  assign bus.rsp_ir    = bus.rsp_valid ? f_ir[rd_ptr]  : last_ir;
  assign bus.rsp_pc    = bus.rsp_valid ? f_pc[rd_ptr]  : last_pc;
  assign bus.rsp_err   = bus.rsp_valid ? f_err[rd_ptr] : last_err;

  // Program load; no reset so contents survive rst. Same-cycle reads see old data.
  always_ff @(posedge clk) begin
    if (bus.ld_we) begin
      rom[bus.ld_addr] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      p_valid <= '0;
    end else begin
      p_valid[0] <= accept;
      for (int i = 1; i < LAT; i++) begin
        p_valid[i] <= p_valid[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    p_ir[0]  <= fetch_ir;
    p_pc[0]  <= bus.req_pc;
    p_err[0] <= fetch_err;
    for (int i = 1; i < LAT; i++) begin
      p_ir[i]  <= p_ir[i-1];
      p_pc[i]  <= p_pc[i-1];
      p_err[i] <= p_err[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      f_ir[wr_ptr]  <= p_ir[LAT-1];
      f_pc[wr_ptr]  <= p_pc[LAT-1];
      f_err[wr_ptr] <= p_err[LAT-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      occ      <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
      occ      <= occ + CW'(accept) - CW'(pop);
    end
  end

  // A pop in a flush cycle still lands here, so the observed head is retained.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_ir  <= '0;
      last_pc  <= '0;
      last_err <= 1'b0;
    end else if (pop) begin
      last_ir  <= f_ir[rd_ptr];
      last_pc  <= f_pc[rd_ptr];
      last_err <= f_err[rd_ptr];
    end
  end

`ifdef IFR_STATS_EN
  logic [16:0] squash_sum;

  // Entries killed by a flush: all occupancy except a head popped that same cycle.
  assign squash_sum = {1'b0, stat_squash} + 17'(occ) - 17'(pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rsp    <= '0;
      stat_squash <= '0;
    end else begin
      if (pop && (stat_rsp != 16'hFFFF)) begin
        stat_rsp <= stat_rsp + 16'd1;
      end
      if (bus.flush) begin
        stat_squash <= squash_sum[16] ? 16'hFFFF : squash_sum[15:0];
      end
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_responder.sv
// Self-checking bench for ifetch_responder: directed scenarios plus randomized traffic
// against a request-order scoreboard with per-entry ready times.
module tb_ifetch_responder;
  localparam int MEM_AW = 8;
  localparam int LAT    = 2;
  localparam int DEPTH  = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  ifetch_responder_if #(.MEM_AW(MEM_AW)) bus ();

`ifdef IFR_STATS_EN
  logic [15:0] stat_rsp;
  logic [15:0] stat_squash;
`endif

  ifetch_responder #(.MEM_AW(MEM_AW), .LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus)
`ifdef IFR_STATS_EN
    ,
    .stat_rsp    (stat_rsp),
    .stat_squash (stat_squash)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model: ROM image, outstanding responses {err, pc, ir} and the cycle each may show
  logic [31:0] model_rom [256];
  logic [64:0] exp_q[$];
  int          rdy_q[$];
  logic [64:0] last_exp;
  int          m_rsp;
  int          m_squash;

  function automatic logic [64:0] expect_of(input logic [31:0] pc);
    logic err;
    logic [31:0] ir;
    err = (pc % 4 != 0) || (pc >= 32'd1024);
    ir  = err ? 32'hFFFF_FFFF : model_rom[pc / 4];
    return {err, pc, ir};
  endfunction

  // scoreboard, evaluated mid-cycle
  always @(negedge clk) begin
    logic        exp_ready;
    logic        exp_valid;
    logic [64:0] head;
    logic [64:0] obs;
    obs = {bus.rsp_err, bus.rsp_pc, bus.rsp_ir};
    if (rst) begin
      n_checks++;
      if (bus.req_ready !== 1'b0) begin
        n_errors++;
        $display("FAIL sb_ready_in_rst: got %b want 0 (cyc %0d)", bus.req_ready, cyc);
      end
      exp_q.delete();
      rdy_q.delete();
      last_exp = '0;
      m_rsp    = 0;
      m_squash = 0;
    end else begin
      exp_ready = !bus.flush && (exp_q.size() < DEPTH);
      exp_valid = (exp_q.size() > 0) && (rdy_q[0] <= cyc);
      head      = exp_valid ? exp_q[0] : last_exp;
      n_checks++;
      if (bus.req_ready !== exp_ready) begin
        n_errors++;
        $display("FAIL sb_req_ready: got %b want %b (cyc %0d)", bus.req_ready, exp_ready, cyc);
      end
      n_checks++;
      if (bus.rsp_valid !== exp_valid) begin
        n_errors++;
        $display("FAIL sb_rsp_valid: got %b want %b (cyc %0d)", bus.rsp_valid, exp_valid, cyc);
      end
      n_checks++;
      if (obs !== head) begin
        n_errors++;
        $display("FAIL sb_rsp_data: got err=%b pc=%h ir=%h want err=%b pc=%h ir=%h (cyc %0d)",
                 obs[64], obs[63:32], obs[31:0], head[64], head[63:32], head[31:0], cyc);
      end
`ifdef IFR_STATS_EN
      n_checks++;
      if (stat_rsp !== 16'(m_rsp) || stat_squash !== 16'(m_squash)) begin
        n_errors++;
        $display("FAIL sb_stats: got rsp=%0d squash=%0d want rsp=%0d squash=%0d",
                 stat_rsp, stat_squash, m_rsp, m_squash);
      end
`endif
      if (exp_valid && bus.rsp_ready) begin
        last_exp = exp_q.pop_front();
        void'(rdy_q.pop_front());
        m_rsp++;
      end
      if (bus.flush) begin
        m_squash += exp_q.size();
        exp_q.delete();
        rdy_q.delete();
      end else if (bus.req_valid && exp_ready) begin
        exp_q.push_back(expect_of(bus.req_pc));
        rdy_q.push_back(cyc + LAT + 1);
      end
    end
    if (bus.ld_we) model_rom[bus.ld_addr] = bus.ld_data;
  end

  // driver tasks: entered and left just after a posedge
  task automatic do_load(input logic [7:0] addr, input logic [31:0] data);
    bus.ld_we   = 1'b1;
    bus.ld_addr = addr;
    bus.ld_data = data;
    @(posedge clk); #1;
    bus.ld_we   = 1'b0;
  endtask

  task automatic send(input logic [31:0] pc);
    int n;
    n = 0;
    bus.req_valid = 1'b1;
    bus.req_pc    = pc;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!bus.req_ready) begin
      n_errors++;
      $display("FAIL send_timeout: pc=%h got no accept want accept within 50 cycles", pc);
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp_valid(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (!bus.rsp_valid) begin
      n_errors++;
      $display("FAIL %s_timeout: got rsp_valid=0 want 1 within 50 cycles", tag);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.rsp_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain_timeout: got %0d outstanding want 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_handshake: got ready=%b valid=%b want 1 0", bus.req_ready, bus.rsp_valid);
    end
    n_checks++;
    if (bus.rsp_ir !== 32'd0 || bus.rsp_pc !== 32'd0 || bus.rsp_err !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got ir=%h pc=%h err=%b want zeros", bus.rsp_ir, bus.rsp_pc, bus.rsp_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_in_order();
    int acc0;
    int seen;
    int budget;
    do_load(8'd0, 32'h1111_1111);
    do_load(8'd1, 32'h2222_2222);
    do_load(8'd2, 32'h3333_3333);
    do_load(8'd3, 32'h4444_4444);
    bus.rsp_ready = 1'b1;
    acc0 = -1;
    seen = 0;
    budget = 0;
    fork
      begin
        for (int k = 0; k < 4; k++) send(32'(k * 4));
      end
      begin
        while (seen < 4 && budget < 40) begin
          @(negedge clk);
          budget++;
          if (acc0 < 0 && bus.req_valid && bus.req_ready) acc0 = cyc;
          if (bus.rsp_valid && bus.rsp_ready) begin
            if (seen == 0) begin
              n_checks++;
              if (cyc - acc0 != LAT + 1) begin
                n_errors++;
                $display("FAIL order_latency: got %0d want %0d", cyc - acc0, LAT + 1);
              end
            end
            n_checks++;
            if (bus.rsp_ir !== 32'h1111_1111 * 32'(seen + 1) || bus.rsp_pc !== 32'(seen * 4) ||
                bus.rsp_err !== 1'b0) begin
              n_errors++;
              $display("FAIL order_rsp%0d: got ir=%h pc=%h err=%b want ir=%h pc=%h err=0", seen,
                       bus.rsp_ir, bus.rsp_pc, bus.rsp_err, 32'h1111_1111 * 32'(seen + 1), seen * 4);
            end
            seen++;
          end
        end
        n_checks++;
        if (seen != 4) begin
          n_errors++;
          $display("FAIL order_count: got %0d responses want 4", seen);
        end
      end
    join
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_backpressure();
    int accepts;
    logic took;
    accepts = 0;
    bus.rsp_ready = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_pc    = 32'd0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      took = bus.req_ready;
      if (took) accepts++;
      @(posedge clk); #1;
      if (took) bus.req_pc = bus.req_pc + 32'd4;
    end
    bus.req_valid = 1'b0;
    n_checks++;
    if (accepts != DEPTH) begin
      n_errors++;
      $display("FAIL bp_accepts: got %0d want %0d", accepts, DEPTH);
    end
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL bp_full_ready: got %b want 0", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL bp_ready_after_pop: got %b want 1", bus.req_ready);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_errors();
    bus.rsp_ready = 1'b0;
    send(32'h0000_0006);
    send(32'h0000_0400);
    wait_rsp_valid("err_first");
    n_checks++;
    if (bus.rsp_ir !== 32'hFFFF_FFFF || bus.rsp_err !== 1'b1 || bus.rsp_pc !== 32'h6) begin
      n_errors++;
      $display("FAIL err_misaligned: got ir=%h err=%b pc=%h want ffffffff 1 00000006",
               bus.rsp_ir, bus.rsp_err, bus.rsp_pc);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_ir !== 32'hFFFF_FFFF || bus.rsp_err !== 1'b1 ||
        bus.rsp_pc !== 32'h400) begin
      n_errors++;
      $display("FAIL err_out_of_range: got v=%b ir=%h err=%b pc=%h want 1 ffffffff 1 00000400",
               bus.rsp_valid, bus.rsp_ir, bus.rsp_err, bus.rsp_pc);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_flush();
    int s0;
    s0 = m_squash;
    bus.rsp_ready = 1'b0;
    send(32'h20);
    send(32'h24);
    send(32'h28);
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_pc    = 32'h2c;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL flush_no_accept: got req_ready=%b want 0", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.flush     = 1'b0;
    bus.req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL flush_after: got valid=%b ready=%b want 0 1", bus.rsp_valid, bus.req_ready);
    end
`ifdef IFR_STATS_EN
    n_checks++;
    if (stat_squash !== 16'(s0 + 3)) begin
      n_errors++;
      $display("FAIL flush_squash: got %0d want %0d", stat_squash, s0 + 3);
    end
`endif
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_checks++;
      if (bus.rsp_valid !== 1'b0) begin
        n_errors++;
        $display("FAIL flush_stale: got rsp_valid=1 pc=%h want no response", bus.rsp_pc);
      end
    end
    @(posedge clk); #1;
    if (s0 < 0) $display("note: squash baseline %0d", s0);
  endtask

  task automatic test_load_collision();
    logic [31:0] old;
    old = model_rom[5];
    bus.rsp_ready = 1'b0;
    bus.ld_we     = 1'b1;
    bus.ld_addr   = 8'd5;
    bus.ld_data   = 32'hDEAD_BEEF;
    bus.req_valid = 1'b1;
    bus.req_pc    = 32'd20;
    @(negedge clk);
    n_checks++;
    if (bus.req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL ld_coll_accept: got req_ready=%b want 1", bus.req_ready);
    end
    @(posedge clk); #1;
    bus.ld_we     = 1'b0;
    bus.req_valid = 1'b0;
    wait_rsp_valid("ld_coll_old");
    n_checks++;
    if (bus.rsp_ir !== old) begin
      n_errors++;
      $display("FAIL ld_coll_old: got %h want %h", bus.rsp_ir, old);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    send(32'd20);
    wait_rsp_valid("ld_coll_new");
    n_checks++;
    if (bus.rsp_ir !== 32'hDEAD_BEEF) begin
      n_errors++;
      $display("FAIL ld_coll_new: got %h want deadbeef", bus.rsp_ir);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_reset_mid();
    bus.rsp_ready = 1'b0;
    send(32'd0);
    send(32'd4);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_ir !== 32'd0 || bus.rsp_pc !== 32'd0 ||
        bus.rsp_err !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_errors++;
      $display("FAIL rst_mid_outputs: got v=%b ir=%h pc=%h err=%b ready=%b want 0 0 0 0 1",
               bus.rsp_valid, bus.rsp_ir, bus.rsp_pc, bus.rsp_err, bus.req_ready);
    end
    @(posedge clk); #1;
    send(32'd0);
    wait_rsp_valid("rst_mid_fetch");
    n_checks++;
    if (bus.rsp_ir !== 32'h1111_1111 || bus.rsp_pc !== 32'd0) begin
      n_errors++;
      $display("FAIL rst_mid_rom: got ir=%h pc=%h want 11111111 00000000", bus.rsp_ir, bus.rsp_pc);
    end
    @(posedge clk); #1;
    drain();
  endtask

  task automatic test_random();
    int r;
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 15);
      bus.req_valid = ($urandom_range(0, 3) != 0);
      if (r == 0)      bus.req_pc = 32'($urandom_range(0, 255) * 4 + $urandom_range(1, 3));
      else if (r == 1) bus.req_pc = 32'h400 + 32'($urandom_range(0, 4095) * 4);
      else             bus.req_pc = 32'($urandom_range(0, 255) * 4);
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      bus.flush     = ($urandom_range(0, 39) == 0);
      bus.ld_we     = ($urandom_range(0, 9) == 0);
      bus.ld_addr   = 8'($urandom_range(0, 255));
      bus.ld_data   = $urandom;
      @(posedge clk); #1;
    end
    bus.ld_we = 1'b0;
    drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish want finish before 1000000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_pc    = '0;
    bus.flush     = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.ld_we     = 1'b0;
    bus.ld_addr   = '0;
    bus.ld_data   = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) do_load(8'(i), $urandom);
    test_reset();
    test_in_order();
    test_backpressure();
    test_errors();
    test_flush();
    test_load_collision();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
